mem_arbiter: RTL and testbench

- Shares the single-port 32x8 program/data memory between two requesters: port 0 = CPU sequencing logic (fetch/operand/store accesses), port 1 = loader/debug port (program download, memory inspection).
- Sits between the requesters and the memory.
- Provides single-beat req/ack transfers, registered ownership, round-robin on contention, and a burst limit so neither side starves.

---
 rtl/mem_arbiter.sv | 177 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port arbiter for the shared single-port program/data memory: round-robin on ties, burst limit on contention.
// Optional beat counters are compiled in with `define ARB_STATS_EN.
module mem_arbiter #(
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 8,
  parameter int BURST_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
`ifdef ARB_STATS_EN
  input  logic              clr_stats,
  output logic [15:0]       beats0,
  output logic [15:0]       beats1,
`endif
  output logic              gnt0,
  output logic              gnt1,
  output logic              ack0,
  output logic              ack1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  // One bit per owner so each grant flag is a flop output, never a decode.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_t;

  localparam logic [4:0] BURST_LIM = 5'(BURST_MAX);

  state_t     state;
  state_t     state_nxt;
  logic       last_gnt;
  logic [3:0] burst_cnt;
  logic       beat;
  logic       other_req;
  logic [4:0] burst_next;
  logic       burst_hit;

  // Owner-relative view: the current owner's beat and the competing request.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    beat      = 1'b0;
    other_req = 1'b0;
    unique case (state)
      OWN0: begin
        beat      = req0;
        other_req = req1;
      end
      OWN1: begin
        beat      = req1;
        other_req = req0;
      end
      default: ;
    endcase
  end

  assign burst_next = {1'b0, burst_cnt} + 5'd1;
  assign burst_hit  = beat && other_req && (burst_next >= BURST_LIM);

  // State register; the pointer remembers who owned the bus last so ties alternate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state    <= IDLE;
      last_gnt <= 1'b1;
    end else begin
      state <= state_nxt;
      if (state != state_nxt) begin
        if (state == OWN0) last_gnt <= 1'b0;
        if (state == OWN1) last_gnt <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (req0 && req1) state_nxt = last_gnt ? OWN0 : OWN1;
        else if (req0)    state_nxt = OWN0;
        else if (req1)    state_nxt = OWN1;
      end
      OWN0: begin
        if (!req0)          state_nxt = req1 ? OWN1 : IDLE;
        else if (burst_hit) state_nxt = OWN1;
      end
      OWN1: begin
        if (!req1)          state_nxt = req0 ? OWN0 : IDLE;
        else if (burst_hit) state_nxt = OWN0;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Counts beats only while the other side is waiting; a sole requester never hits the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      burst_cnt <= '0;
    end else if ((state_nxt != state) || !other_req) begin
      burst_cnt <= '0;
    end else if (beat && (burst_next <= BURST_LIM)) begin
      burst_cnt <= burst_cnt + 4'd1;
    end
  end

  assign gnt0 = state[0];
  assign gnt1 = state[1];
  assign ack0 = gnt0 & req0;
  assign ack1 = gnt1 & req1;

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    unique case (state)
      OWN0: begin
        mem_addr  = addr0;
        mem_wdata = wdata0;
        mem_rd    = req0 & ~we0;
        mem_wr    = req0 & we0;
      end
      OWN1: begin
        mem_addr  = addr1;
        mem_wdata = wdata1;
        mem_rd    = req1 & ~we1;
        mem_wr    = req1 & we1;
      end
      default: ;
    endcase
  end

  // Read data comes back one cycle after the strobe, even if ownership moved meanwhile.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
    end else begin
      rvalid0 <= ack0 & ~we0;
      rvalid1 <= ack1 & ~we1;
    end
  end

  assign rdata = mem_rdata;

`ifdef ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beats0 <= '0;
      beats1 <= '0;
    end else if (clr_stats) begin
      beats0 <= '0;
      beats1 <= '0;
    end else begin
      if (ack0 && (beats0 != 16'hFFFF)) beats0 <= beats0 + 16'd1;
      if (ack1 && (beats1 != 16'hFFFF)) beats1 <= beats1 + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed sequences plus a read-data scoreboard fed by a memory model.
// Build with +define+ARB_STATS_EN to also exercise the beat counters.
module tb_mem_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [4:0] addr0 = '0, addr1 = '0;
  logic [7:0] wdata0 = '0, wdata1 = '0;
  logic       gnt0, gnt1, ack0, ack1, rvalid0, rvalid1;
  logic [7:0] rdata, mem_wdata, mem_rdata;
  logic [4:0] mem_addr;
  logic       mem_rd, mem_wr;
`ifdef ARB_STATS_EN
  logic        clr_stats = 1'b0;
  logic [15:0] beats0, beats1;
`endif

  int err_cnt = 0;
  int chk_cnt = 0;

  logic [7:0] mem     [32];
  logic [7:0] exp_mem [32];
  logic [7:0] q0 [$];
  logic [7:0] q1 [$];

  mem_arbiter #(.ADDR_W(5), .DATA_W(8), .BURST_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
`ifdef ARB_STATS_EN
    .clr_stats(clr_stats), .beats0(beats0), .beats1(beats1),
`endif
    .gnt0(gnt0), .gnt1(gnt1), .ack0(ack0), .ack1(ack1),
    .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata(rdata),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] init_val(input int i);
    return 8'hA5 ^ 8'(i ^ 3);
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Synchronous memory model behind the arbiter.
  initial for (int i = 0; i < 32; i++) mem[i] <= init_val(i);
  initial for (int i = 0; i < 32; i++) exp_mem[i] = init_val(i);

  always @(posedge clk) begin
    if (mem_wr) mem[mem_addr] <= mem_wdata;
    if (mem_rd) mem_rdata <= mem[mem_addr];
  end

  // Scoreboard: reads acked this cycle must return next cycle with the requester's expected data.
  always @(negedge clk) begin
    logic [7:0] e;
    if (!rst_n) begin
      q0.delete();
      q1.delete();
      check("rst_quiet", 32'({gnt1, gnt0, ack1, ack0, rvalid1, rvalid0, mem_rd, mem_wr}), 32'd0);
    end else begin
      check("gnt_excl", 32'(gnt0 & gnt1), 32'd0);
      check("strobe_excl", 32'(mem_rd & mem_wr), 32'd0);
      if (q0.size() > 0) begin
        e = q0.pop_front();
        check("sb_rvalid0", 32'(rvalid0), 32'd1);
        check("sb_rdata0", 32'(rdata), 32'(e));
      end else check("sb_rvalid0_idle", 32'(rvalid0), 32'd0);
      if (q1.size() > 0) begin
        e = q1.pop_front();
        check("sb_rvalid1", 32'(rvalid1), 32'd1);
        check("sb_rdata1", 32'(rdata), 32'(e));
      end else check("sb_rvalid1_idle", 32'(rvalid1), 32'd0);
      if (ack0) begin
        if (we0) exp_mem[addr0] = wdata0;
        else     q0.push_back(exp_mem[addr0]);
      end
      if (ack1) begin
        if (we1) exp_mem[addr1] = wdata1;
        else     q1.push_back(exp_mem[addr1]);
      end
    end
  end

  task automatic pulse_reset(input string tag);
    rst_n = 1'b0;
    #1;
    check({tag, "_gnt"},    32'({gnt1, gnt0}), 32'd0);
    check({tag, "_ack"},    32'({ack1, ack0}), 32'd0);
    check({tag, "_rvalid"}, 32'({rvalid1, rvalid0}), 32'd0);
    check({tag, "_strobe"}, 32'({mem_rd, mem_wr}), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Issues n beats on one port, bounded wait, then drops the request.
  task automatic do_beats(input int port, input int n, input logic we,
                          input logic [4:0] addr, input logic [7:0] data);
    int got = 0;
    int waited = 0;
    @(posedge clk); #1;
    if (port == 0) begin req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = data; end
    else           begin req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = data; end
    while (got < n && waited < n + 8) begin
      @(negedge clk);
      waited++;
      if ((port == 0) ? ack0 : ack1) got++;
    end
    @(posedge clk); #1;
    if (port == 0) req0 = 1'b0; else req1 = 1'b0;
    check("beats_done", 32'(got), 32'(n));
  endtask

  initial begin
    logic [1:0] exp_g;
    int a0, a1, wr_cnt;

    // Reset state.
    #2;
    pulse_reset("t1");

    // Single read on port 0.
    @(posedge clk); #1 req0 = 1'b1; we0 = 1'b0; addr0 = 5'h03;
    @(negedge clk); check("t2_latency", 32'(gnt0), 32'd0);
    @(negedge clk);
    check("t2_gnt0", 32'(gnt0), 32'd1);
    check("t2_ack0", 32'(ack0), 32'd1);
    check("t2_rd", 32'({mem_rd, mem_wr}), 32'b10);
    check("t2_addr", 32'(mem_addr), 32'h03);
    @(posedge clk); #1 req0 = 1'b0;
    @(negedge clk);
    check("t2_rvalid0", 32'(rvalid0), 32'd1);
    check("t2_rdata", 32'(rdata), 32'hA5);
    repeat (2) @(posedge clk);

    // Contention from a fresh reset: 4 beats each, no idle at handoff.
    @(posedge clk); #2;
    pulse_reset("t3rst");
    @(posedge clk); #1;
    req0 = 1'b1; we0 = 1'b0; addr0 = 5'h0A;
    req1 = 1'b1; we1 = 1'b0; addr1 = 5'h15;
    a0 = 0; a1 = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      exp_g = (i == 0) ? 2'b00 : (i <= 4) ? 2'b01 : (i <= 8) ? 2'b10 : 2'b01;
      check("t3_gnt", 32'({gnt1, gnt0}), 32'(exp_g));
      if (i == 5) check("t3_handoff_rv0", 32'(rvalid0), 32'd1);
      if (i < 9) begin a0 += int'(ack0); a1 += int'(ack1); end
    end
    check("t3_acks0", 32'(a0), 32'd4);
    check("t3_acks1", 32'(a1), 32'd4);
    @(posedge clk); #1 req0 = 1'b0; req1 = 1'b0;
    repeat (2) @(posedge clk);

    // Sole requester keeps the bus for 20 writes.
    @(posedge clk); #1 req1 = 1'b1; we1 = 1'b1; addr1 = 5'd0; wdata1 = 8'h40;
    @(negedge clk); check("t4_latency", 32'(gnt1), 32'd0);
    a1 = 0; wr_cnt = 0; a0 = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      a1 += int'(ack1);
      wr_cnt += int'(mem_wr);
      a0 += int'(!gnt1);
      check("t4_addr", 32'(mem_addr), 32'(i));
      @(posedge clk); #1;
      if (i < 19) begin addr1 = 5'(i + 1); wdata1 = 8'(8'h40 + i + 1); end
      else req1 = 1'b0;
    end
    check("t4_acks", 32'(a1), 32'd20);
    check("t4_writes", 32'(wr_cnt), 32'd20);
    check("t4_gnt_drops", 32'(a0), 32'd0);
    do_beats(0, 1, 1'b0, 5'd7, 8'h00);
    @(negedge clk);
    check("t4_rb_rvalid", 32'(rvalid0), 32'd1);
    check("t4_rb_rdata", 32'(rdata), 32'h47);
    repeat (2) @(posedge clk);

    // Port 1 reads 1F then hands over to a waiting port 0.
    @(posedge clk); #1 req1 = 1'b1; we1 = 1'b0; addr1 = 5'h1F;
    @(negedge clk);
    @(negedge clk);
    check("t5_ack1", 32'(ack1), 32'd1);
    check("t5_addr", 32'(mem_addr), 32'h1F);
    @(posedge clk); #1 req1 = 1'b0; req0 = 1'b1; we0 = 1'b0; addr0 = 5'h02;
    @(negedge clk);
    check("t5_rvalid1", 32'(rvalid1), 32'd1);
    check("t5_rvalid0", 32'(rvalid0), 32'd0);
    check("t5_no_ack", 32'({ack1, ack0}), 32'd0);
    @(negedge clk);
    check("t5_gnt", 32'({gnt1, gnt0}), 32'b01);
    check("t5_ack0", 32'(ack0), 32'd1);
    @(posedge clk); #1 req0 = 1'b0;
    repeat (2) @(posedge clk);

    // Reset mid-burst with a read in flight; tie afterwards goes to port 0.
    @(posedge clk); #1;
    req0 = 1'b1; we0 = 1'b0; addr0 = 5'h04;
    req1 = 1'b1; we1 = 1'b0; addr1 = 5'h09;
    @(negedge clk);
    @(negedge clk);
    check("t6_pre_gnt", 32'({gnt1, gnt0}), 32'b10);
    @(posedge clk); #1;
    check("t6_inflight", 32'(rvalid1), 32'd1);
    pulse_reset("t6");
    @(negedge clk); check("t6_idle", 32'({gnt1, gnt0}), 32'b00);
    @(negedge clk); check("t6_first", 32'({gnt1, gnt0}), 32'b01);
    @(posedge clk); #1 req0 = 1'b0; req1 = 1'b0;
    repeat (3) @(posedge clk);

`ifdef ARB_STATS_EN
    @(posedge clk); #2;
    pulse_reset("st");
    check("st_rst0", 32'(beats0), 32'd0);
    check("st_rst1", 32'(beats1), 32'd0);
    do_beats(0, 7, 1'b1, 5'h1E, 8'h11);
    do_beats(1, 3, 1'b1, 5'h1D, 8'h22);
    @(negedge clk);
    check("st_beats0", 32'(beats0), 32'd7);
    check("st_beats1", 32'(beats1), 32'd3);
    @(posedge clk); #1 req0 = 1'b1; we0 = 1'b1; addr0 = 5'h1C;
    @(negedge clk);
    @(negedge clk); check("st_ack", 32'(ack0), 32'd1);
    @(posedge clk); #1 clr_stats = 1'b1;
    @(negedge clk); check("st_clr_ack", 32'(ack0), 32'd1);
    @(posedge clk); #1 clr_stats = 1'b0;
    @(negedge clk);
    check("st_clr0", 32'(beats0), 32'd0);
    check("st_clr1", 32'(beats1), 32'd0);
    @(posedge clk); #1 req0 = 1'b0;
    @(negedge clk); check("st_after", 32'(beats0), 32'd1);
    repeat (2) @(posedge clk);
`endif

    @(negedge clk);
    check("sb_empty", 32'(q0.size() + q1.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
